conv1_window_ctrl: RTL and testbench
====================================

# conv1_window_ctrl

Sequencer for the first binary convolution layer. Accepts a 1-bit MNIST image in raster order through a valid/ready stream, keeps two image lines plus three pixels in a shift-register line buffer, and presents each valid 3x3 window as `pixel_0`..`pixel_8` with `valid_out_buf` to the 8-channel XNOR/popcount conv1 datapath. Frame-level control uses `start`, `busy` and `done`.

## Interface
- `IMG_W`, 28: image width in pixels.
- `IMG_H`, 28: image height in pixels.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low; one clock; all state resets on a `clk` edge with `rst_n`=0.
- `start`  in  1  begin frame; sampled only in IDLE.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse after the last window is consumed.
- `pix_in`  in  1  binary input pixel.
- `pix_valid`  in  1  `pix_in` valid.
- `pix_ready`  out  1  block accepts `pix_in` this cycle.
- `pixel_0`..`pixel_8`  out  1 each  window, row-major; `pixel_0` top-left, `pixel_8` bottom-right.
- `valid_out_buf`  out  1  window valid.
- `win_row`, `win_col`  out  5 each  output coordinates of the window, range 0..IMG_H-3 / 0..IMG_W-3.
- `out_ready`  in  1  downstream accepts the window. Present only with `CONV1_BACKPRESSURE_EN`.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: on `start`, clear the counters and the shift register, then go to RUN.
  - RUN: accept pixels. After the pixel at (IMG_H-1, IMG_W-1) is accepted, go to DRAIN.
  - DRAIN: when the final window is consumed, go to DONE.
  - DONE: assert `done` for one cycle, then go to IDLE.
- `start` outside IDLE is ignored.
- Accept condition: `pix_valid && pix_ready`.
- `pix_ready` = state==RUN && (!`valid_out_buf` || `out_ready`).
- Shift register width is 2*IMG_W+3. The accepted pixel enters bit 0 and existing bits shift up by one.
- Window taps:
  - `pixel_8`=sr[0], `pixel_7`=sr[1], `pixel_6`=sr[2]
  - `pixel_5`=sr[W], `pixel_4`=sr[W+1], `pixel_3`=sr[W+2]
  - `pixel_2`=sr[2W], `pixel_1`=sr[2W+1], `pixel_0`=sr[2W+2]
  - These taps are taken after the shift and registered into the output window.
- Counters `row`/`col` track the accepted pixel. `col` wraps at IMG_W-1 and increments `row`; `row` saturates after the last pixel.
- A window is produced when the accepted pixel satisfies row>=2 && col>=2. In that case `win_row`=row-2 and `win_col`=col-2.
- A default 28x28 frame produces exactly 676 windows.
- Windows never span a line wrap, because columns 0 and 1 never produce one.
- A window is consumed when `valid_out_buf` && `out_ready`. If a consume and a new accept occur in the same cycle, the new window overwrites the outputs and `valid_out_buf` stays 1.

## Timing
- Reset values: `busy`=0, `done`=0, `pix_ready`=0, `valid_out_buf`=0, `pixel_0`..`pixel_8`=0, `win_row`=0, `win_col`=0, state IDLE, shift register all 0.
- `start` is sampled at edge N; `busy` and `pix_ready` rise at N+1.
- Latency: a window-producing pixel accepted at edge N gives `valid_out_buf` high after edge N, i.e. one cycle.
- Window outputs are held stable while `valid_out_buf`=1 and `out_ready`=0.
- Best case, a frame takes IMG_W*IMG_H accept cycles plus 3 cycles: the last window, DONE, and the return to IDLE.
- `busy` falls in the same cycle that `done` is high.
- Reset asserted mid-frame: the block returns to IDLE with all outputs at reset values. No `done` pulse, and any partial window is discarded.
- `pix_valid` gaps stall the scan without losing state.

## Configuration
- `CONV1_BACKPRESSURE_EN` defined:
  - `out_ready` port exists.
  - `pix_ready` and window hold follow the rules above.
  - DRAIN waits for `out_ready`.
- Not defined:
  - `out_ready` port is absent and internally tied to 1.
  - `valid_out_buf` is a one-cycle pulse per window.
  - DRAIN lasts exactly one cycle.

## Structure
- Package `conv1_pkg`: IMG_W/IMG_H defaults, KERNEL_SIZE=3, WINDOW_SIZE=9, the FSM state enum, and the coordinate width (5).
- Sub-module `conv1_line_buf`: parameterised shift register with shift enable and synchronous clear, exposing the nine taps.
- The FSM, counters and output register live in the top module.

## Test plan
- Reset mid-frame: assert `rst_n`=0 after 100 pixels → all outputs 0 next edge, state IDLE. A later `start` then yields 676 windows.
- All-ones frame, `pix_valid` continuous → 676 windows, each with `pixel_0`..`pixel_8`=1. First window at `win_row`=0, `win_col`=0, appearing one cycle after pixel index 58 is accepted. `done` pulses once.
- Raster-index pattern (pixel=1 only at (5,7)) → exactly 9 windows have one set bit. Window (3,5) has `pixel_8`=1 and window (5,7) has `pixel_0`=1.
- Random `pix_valid` gaps (50% duty) → window stream identical to the gap-free run, and `win_col` never exceeds 25.
- Backpressure (`CONV1_BACKPRESSURE_EN`), `out_ready` low for 10 cycles on window (0,0) → `pix_ready`=0 and the window is held stable. No window is lost, and 676 are counted.
- `start` pulsed while `busy` → ignored, and the frame completes normally with a single `done`.

Source files
------------

// File: rtl/conv1_pkg.sv
// Shared constants and types for the conv1 window sequencer.
package conv1_pkg;

  localparam int unsigned DEF_IMG_W   = 28;
  localparam int unsigned DEF_IMG_H   = 28;
  localparam int unsigned KERNEL_SIZE = 3;
  localparam int unsigned WINDOW_SIZE = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned COORD_W     = 5;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/conv1_window_ctrl_if.sv
// Pixel stream in / 3x3 window out bundle for conv1_window_ctrl.
// out_ready exists only when CONV1_BACKPRESSURE_EN is defined.
interface conv1_window_ctrl_if;

  logic                           pix_in;
  logic                           pix_valid;
  logic                           pix_ready;
  logic                           pixel_0, pixel_1, pixel_2;
  logic                           pixel_3, pixel_4, pixel_5;
  logic                           pixel_6, pixel_7, pixel_8;
  logic                           valid_out_buf;
  logic [conv1_pkg::COORD_W-1:0]  win_row;
  logic [conv1_pkg::COORD_W-1:0]  win_col;

`ifdef CONV1_BACKPRESSURE_EN
  logic                           out_ready;

  modport master (
    output pix_in, pix_valid, out_ready,
    input  pix_ready, pixel_0, pixel_1, pixel_2, pixel_3, pixel_4, pixel_5, pixel_6, pixel_7,
    input  pixel_8, valid_out_buf, win_row, win_col
  );

  modport slave (
    input  pix_in, pix_valid, out_ready,
    output pix_ready, pixel_0, pixel_1, pixel_2, pixel_3, pixel_4, pixel_5, pixel_6, pixel_7,
    output pixel_8, valid_out_buf, win_row, win_col
  );
`else
  modport master (
    output pix_in, pix_valid,
    input  pix_ready, pixel_0, pixel_1, pixel_2, pixel_3, pixel_4, pixel_5, pixel_6, pixel_7,
    input  pixel_8, valid_out_buf, win_row, win_col
  );

  modport slave (
    input  pix_in, pix_valid,
    output pix_ready, pixel_0, pixel_1, pixel_2, pixel_3, pixel_4, pixel_5, pixel_6, pixel_7,
    output pixel_8, valid_out_buf, win_row, win_col
  );
`endif

endinterface

// File: rtl/conv1_line_buf.sv
// Two-line-plus-three-pixel shift register; taps are taken from the post-shift value so the
// caller can register a complete window in the same cycle the pixel is accepted.
module conv1_line_buf
  import conv1_pkg::*;
#(
  parameter int unsigned ImgW = DEF_IMG_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   shift_en,
  input  logic                   din,
  output logic [WINDOW_SIZE-1:0] taps
);

  localparam int unsigned Len = 2 * ImgW + 3;

  logic [Len-1:0] sr_q;
  logic [Len-1:0] sr_shift;
  logic           unused_msb;

  assign sr_shift   = {sr_q[Len-2:0], din};
  // Oldest bit only feeds the tap via sr_shift; its own stored copy is never read.
  assign unused_msb = sr_q[Len-1];

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      sr_q <= '0;
    end else if (shift_en) begin
      sr_q <= sr_shift;
    end
  end

  always_comb begin
    taps    = '0;
    taps[8] = sr_shift[0];
    taps[7] = sr_shift[1];
    taps[6] = sr_shift[2];
    taps[5] = sr_shift[ImgW];
    taps[4] = sr_shift[ImgW+1];
    taps[3] = sr_shift[ImgW+2];
    taps[2] = sr_shift[2*ImgW];
    taps[1] = sr_shift[2*ImgW+1];
    taps[0] = sr_shift[2*ImgW+2];
  end

endmodule

// File: rtl/conv1_window_ctrl.sv
// Frame sequencer for conv1: raster pixel intake, 3x3 window presentation, start/busy/done.
// Define CONV1_BACKPRESSURE_EN to add out_ready and hold windows until consumed.
module conv1_window_ctrl
  import conv1_pkg::*;
#(
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned IMG_H = DEF_IMG_H
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  conv1_window_ctrl_if.slave   win_if
);

  state_e                 state_q, state_d;
  coord_t                 row_q, row_d, col_q, col_d;
  coord_t                 win_row_q, win_row_d, win_col_q, win_col_d;
  logic [WINDOW_SIZE-1:0] win_q, win_d, taps;
  logic                   vob_q, vob_d;
  logic                   out_ready, pix_ready, accept, win_hit, last_pix, clr;

`ifdef CONV1_BACKPRESSURE_EN
  assign out_ready = win_if.out_ready;
`else
  assign out_ready = 1'b1;
`endif

  conv1_line_buf #(
    .ImgW (IMG_W)
  ) u_line_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .shift_en (accept),
    .din      (win_if.pix_in),
    .taps     (taps)
  );

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    clr       = 1'b0;
    pix_ready = (state_q == StRun) && (!vob_q || out_ready);
    accept    = win_if.pix_valid && pix_ready;
    win_hit   = accept && (row_q >= coord_t'(2)) && (col_q >= coord_t'(2));
    last_pix  = (row_q == coord_t'(IMG_H - 1)) && (col_q == coord_t'(IMG_W - 1));
    busy      = (state_q == StRun) || (state_q == StDrain);
    done      = (state_q == StDone);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          clr     = 1'b1;
          row_d   = '0;
          col_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (accept) begin
          if (col_q == coord_t'(IMG_W - 1)) begin
            col_d = '0;
            if (!last_pix) row_d = row_q + coord_t'(1);
          end else begin
            col_d = col_q + coord_t'(1);
          end
          if (last_pix) state_d = StDrain;
        end
      end
      StDrain: begin
        if (!vob_q || out_ready) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    vob_d     = vob_q;
    win_d     = win_q;
    win_row_d = win_row_q;
    win_col_d = win_col_q;
    // A fresh window wins over a same-cycle consume, so valid stays high.
    if (win_hit) begin
      vob_d     = 1'b1;
      win_d     = taps;
      win_row_d = row_q - coord_t'(2);
      win_col_d = col_q - coord_t'(2);
    end else if (vob_q && out_ready) begin
      vob_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      row_q     <= '0;
      col_q     <= '0;
      vob_q     <= 1'b0;
      win_q     <= '0;
      win_row_q <= '0;
      win_col_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      vob_q     <= vob_d;
      win_q     <= win_d;
      win_row_q <= win_row_d;
      win_col_q <= win_col_d;
    end
  end

  assign win_if.pix_ready     = pix_ready;
  assign win_if.valid_out_buf = vob_q;
  assign win_if.win_row       = win_row_q;
  assign win_if.win_col       = win_col_q;
  assign win_if.pixel_0       = win_q[0];
  assign win_if.pixel_1       = win_q[1];
  assign win_if.pixel_2       = win_q[2];
  assign win_if.pixel_3       = win_q[3];
  assign win_if.pixel_4       = win_q[4];
  assign win_if.pixel_5       = win_q[5];
  assign win_if.pixel_6       = win_q[6];
  assign win_if.pixel_7       = win_q[7];
  assign win_if.pixel_8       = win_q[8];

endmodule

// File: tb/tb_conv1_window_ctrl.sv
// Scoreboard bench for conv1_window_ctrl: expected windows are computed from an image model
// when each pixel is accepted and compared when the DUT presents them.
module tb_conv1_window_ctrl;
  import conv1_pkg::*;

  localparam int W    = 28;
  localparam int H    = 28;
  localparam int NWIN = (W - 2) * (H - 2);

  typedef struct {
    int         row;
    int         col;
    logic [8:0] bits;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done;
  logic out_ready_tb = 1'b1;

  conv1_window_ctrl_if wif ();

`ifdef CONV1_BACKPRESSURE_EN
  assign wif.out_ready = out_ready_tb;
  localparam bit BP_ON = 1'b1;
`else
  localparam bit BP_ON = 1'b0;
`endif

  conv1_window_ctrl #(
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .win_if (wif)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  exp_t mon_e;
  logic img [H][W];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_checks = 0;
  int   frame_win, frame_done, one_bit_win, max_col;
  bit   lat_chk;
  logic hit35, hit57;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic logic [8:0] obs_bits();
    return {wif.pixel_8, wif.pixel_7, wif.pixel_6, wif.pixel_5, wif.pixel_4,
            wif.pixel_3, wif.pixel_2, wif.pixel_1, wif.pixel_0};
  endfunction

  function automatic logic [8:0] model_win(input int r, input int c);
    logic [8:0] b;
    for (int k = 0; k < 9; k++) b[k] = img[r - 2 + k / 3][c - 2 + k % 3];
    return b;
  endfunction

  // Window monitor: a window counts when it is consumed.
  always begin
    @(negedge clk);
    #1;
    if (wif.valid_out_buf && out_ready_tb) begin
      check("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("win_row", 32'(wif.win_row), mon_e.row);
        check("win_col", 32'(wif.win_col), mon_e.col);
        check("win_bits", 32'(obs_bits()), 32'(mon_e.bits));
        if (lat_chk) check("win_latency", cyc, mon_e.cyc);
      end
      frame_win++;
      if ($countones(obs_bits()) == 1) one_bit_win++;
      if (int'(wif.win_col) > max_col) max_col = int'(wif.win_col);
      if (wif.win_row == 5'd3 && wif.win_col == 5'd5) hit35 = wif.pixel_8;
      if (wif.win_row == 5'd5 && wif.win_col == 5'd7) hit57 = wif.pixel_0;
    end
    if (done) begin
      frame_done++;
      check("busy_low_at_done", 32'(busy), 0);
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pix_ready"}, 32'(wif.pix_ready), 0);
    check({tag, "_valid"}, 32'(wif.valid_out_buf), 0);
    check({tag, "_bits"}, 32'(obs_bits()), 0);
    check({tag, "_win_row"}, 32'(wif.win_row), 0);
    check({tag, "_win_col"}, 32'(wif.win_col), 0);
  endtask

  task automatic fill_img(input int mode);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (mode)
          0:       img[r][c] = 1'b1;
          1:       img[r][c] = 1'($urandom_range(1));
          default: img[r][c] = (r == 5 && c == 7);
        endcase
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("busy_after_start", 32'(busy), 1);
    check("ready_after_start", 32'(wif.pix_ready), 1);
  endtask

  task automatic feed(input int n_pix, input int gap_pct, input bit bp, input int glitch_at);
    int   idx = 0;
    int   guard = 0;
    int   hold = 0;
    bit   bp_done = 1'b0;
    exp_t e;
    while (idx < n_pix && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (bp && !bp_done && wif.valid_out_buf) begin
        hold    = 10;
        bp_done = 1'b1;
      end
      out_ready_tb  = (hold == 0);
      start         = (idx == glitch_at);
      wif.pix_valid = ($urandom_range(99) >= gap_pct);
      wif.pix_in    = img[idx / W][idx % W];
      #1;
      if (hold > 0) begin
        check("bp_pix_ready", 32'(wif.pix_ready), 0);
        check("bp_held_valid", 32'(wif.valid_out_buf), 1);
        if (sb.size() != 0) begin
          check("bp_held_row", 32'(wif.win_row), sb[0].row);
          check("bp_held_col", 32'(wif.win_col), sb[0].col);
          check("bp_held_bits", 32'(obs_bits()), 32'(sb[0].bits));
        end
        hold--;
      end
      if (wif.pix_valid && wif.pix_ready) begin
        if (idx / W >= 2 && idx % W >= 2) begin
          e.row  = idx / W - 2;
          e.col  = idx % W - 2;
          e.bits = model_win(idx / W, idx % W);
          e.cyc  = cyc + 1;
          sb.push_back(e);
        end
        idx++;
      end
    end
    @(negedge clk);
    wif.pix_valid = 1'b0;
    start         = 1'b0;
    out_ready_tb  = 1'b1;
    check("feed_accepted", idx, n_pix);
  endtask

  task automatic run_frame(input int gap_pct, input bit bp, input int glitch_at,
                           input bit chk_drain);
    int g = 0;
    frame_win   = 0;
    frame_done  = 0;
    one_bit_win = 0;
    max_col     = 0;
    hit35       = 1'b0;
    hit57       = 1'b0;
    lat_chk     = !bp;
    do_start();
    feed(W * H, gap_pct, bp, glitch_at);
    #1;
    while (!done && g < 100) begin
      @(negedge clk);
      #1;
      g++;
    end
    check("done_seen", 32'(done), 1);
    if (chk_drain) check("drain_cycles", g, 1);
    @(negedge clk);
    #1;
    check("idle_busy", 32'(busy), 0);
    check("idle_pix_ready", 32'(wif.pix_ready), 0);
    repeat (3) @(negedge clk);
    check("frame_windows", frame_win, NWIN);
    check("frame_done_pulses", frame_done, 1);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    wif.pix_in    = 1'b0;
    wif.pix_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;

    // All-ones frame, continuous valid.
    fill_img(0);
    run_frame(0, 1'b0, -1, 1'b1);

    // Reset after 100 pixels, then a full random frame (with backpressure when enabled).
    fill_img(1);
    frame_win = 0;
    lat_chk   = 1'b1;
    do_start();
    feed(100, 0, 1'b0, -1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check_idle("midreset");
    sb.delete();
    rst_n = 1'b1;
    run_frame(0, BP_ON, -1, 1'b0);

    // Single set pixel at (5,7).
    fill_img(2);
    run_frame(0, 1'b0, -1, 1'b1);
    check("one_bit_windows", one_bit_win, 9);
    check("win35_pixel8", 32'(hit35), 1);
    check("win57_pixel0", 32'(hit57), 1);

    // Random image, 50% valid gaps, stray start mid-frame.
    fill_img(1);
    run_frame(50, 1'b0, 300, 1'b0);
    check("max_win_col_le_25", 32'(max_col <= 25), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
